// File: rtl/instruction_fetch_sequencer_if.sv
// Fetch-side bus of the instruction fetch sequencer: instruction memory, decode handshake, redirect.
// FETCH_PERF_COUNT_EN adds the FetchCount/StallCount performance counters.
interface instruction_fetch_sequencer_if;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic        DecodeReady;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        ValidOut;
  logic        Halted;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  modport master (
`ifdef FETCH_PERF_COUNT_EN
    output FetchCount,
    output StallCount,
`endif
    output IMemAddress,
    input  IMemInstruction,
    input  DecodeReady,
    input  Redirect,
    input  RedirectTarget,
    output InstrOut,
    output PCPlus4Out,
    output ValidOut,
    output Halted
  );

  modport slave (
`ifdef FETCH_PERF_COUNT_EN
    input  FetchCount,
    input  StallCount,
`endif
    input  IMemAddress,
    output IMemInstruction,
    input  DecodeReady,
    output Redirect,
    output RedirectTarget,
    input  InstrOut,
    input  PCPlus4Out,
    input  ValidOut,
    input  Halted
  );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one word per cycle into a valid/ready output stage,
// handles redirects and halts outside the populated memory. FETCH_PERF_COUNT_EN enables perf counters.
module instruction_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 128
) (
  input logic                          Clk,
  input logic                          Rst,
  instruction_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_p0, pc_d;
  logic [31:0] instr_p1, instr_d;
  logic [31:0] pc_plus4_p1, pc_plus4_d;
  logic        vld_p1, vld_d;
  logic        halted_q, halted_d;
  logic        advance;
  logic        in_range;
  logic [31:0] pc_next;
  logic [31:0] redirect_pc;

  assign advance     = (state_q == RUN) && (!vld_p1 || bus.DecodeReady);
  assign in_range    = {2'b00, pc_p0[31:2]} < MEM_LIMIT;
  assign pc_next     = pc_p0 + 32'd4;
  assign redirect_pc = {bus.RedirectTarget[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_p0;
    instr_d    = instr_p1;
    pc_plus4_d = pc_plus4_p1;
    vld_d      = vld_p1;
    halted_d   = halted_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        if (bus.Redirect) pc_d = redirect_pc;
      end
      RUN, HALT: begin
        if (bus.Redirect) begin
          // Redirect wins over advance/stall and flushes the word in the output stage.
          pc_d     = redirect_pc;
          vld_d    = 1'b0;
          state_d  = RUN;
          halted_d = 1'b0;
        end else if (advance) begin
          if (in_range) begin
            instr_d    = bus.IMemInstruction;
            pc_plus4_d = pc_next;
            vld_d      = 1'b1;
            pc_d       = pc_next;
          end else begin
            state_d  = HALT;
            halted_d = 1'b1;
            vld_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: program counter / control state
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      pc_p0    <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_d;
      halted_q <= halted_d;
    end
  end

  // p1: fetch/decode output stage
  always_ff @(posedge Clk) begin
    if (Rst) begin
      instr_p1    <= 32'd0;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
    end else begin
      instr_p1    <= instr_d;
      pc_plus4_p1 <= pc_plus4_d;
      vld_p1      <= vld_d;
    end
  end

  assign bus.IMemAddress = pc_p0;
  assign bus.InstrOut    = instr_p1;
  assign bus.PCPlus4Out  = pc_plus4_p1;
  assign bus.ValidOut    = vld_p1;
  assign bus.Halted      = halted_q;

`ifdef FETCH_PERF_COUNT_EN
  logic        fetch_en;
  logic        stall_en;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  assign fetch_en = advance && in_range && !bus.Redirect;
  assign stall_en = (state_q == RUN) && vld_p1 && !bus.DecodeReady && !bus.Redirect;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (fetch_en) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_en) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.FetchCount = fetch_cnt;
  assign bus.StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch_sequencer;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_WORDS = 8;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  instruction_fetch_sequencer_if bus();

  instruction_fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  logic [31:0] mem [0:255];
  assign bus.IMemInstruction = mem[bus.IMemAddress[9:2]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
  logic        m_valid, m_halted, m_started;

  task automatic model_edge();
    if (Rst) begin
      m_pc = RESET_PC; m_started = 1'b0; m_valid = 1'b0; m_instr = '0; m_pc4 = '0;
      m_halted = 1'b0; m_fc = '0; m_sc = '0;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (bus.Redirect) m_pc = bus.RedirectTarget & 32'hFFFF_FFFC;
    end else if (bus.Redirect) begin
      m_pc = bus.RedirectTarget & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_valid && !bus.DecodeReady) begin
      m_sc = m_sc + 1;
    end else if ((m_pc / 4) < MEM_WORDS) begin
      m_instr = mem[m_pc[9:2]]; m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
      m_fc = m_fc + 1;
    end else begin
      m_halted = 1'b1; m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [97:0] act_vec();
    return {bus.IMemAddress, bus.InstrOut, bus.PCPlus4Out, bus.ValidOut, bus.Halted};
  endfunction

  function automatic logic [97:0] exp_vec();
    return {m_pc, m_instr, m_pc4, m_valid, m_halted};
  endfunction

  task automatic test_reset();
    Rst = 1'b1; bus.Redirect = 1'b1; bus.RedirectTarget = 32'h0000_0044; bus.DecodeReady = 1'b0;
    tick(); tick();
    checks++;
    if (act_vec() !== {RESET_PC, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state actual=%h required=%h", act_vec(), {RESET_PC, 96'd0, 2'b00});
    end
    Rst = 1'b0; bus.Redirect = 1'b0; bus.DecodeReady = 1'b1;
    tick();
    checks++;
    if (bus.ValidOut !== 1'b0) begin
      errors++; $display("FAIL first_edge_valid actual=%b required=0", bus.ValidOut);
    end
    tick();
    checks++;
    if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out} !== {1'b1, mem[0], 32'd4}) begin
      errors++; $display("FAIL first_fetch actual=%b/%h/%h required=1/%h/4", bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, mem[0]);
    end
  endtask

  task automatic test_straight_line();
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out} !== {1'b1, mem[k], 32'(4 * (k + 1))}) begin
        errors++; $display("FAIL straight_line_%0d actual=%b/%h/%h required=1/%h/%0d", k, bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, mem[k], 4 * (k + 1));
      end
    end
  endtask

  task automatic test_stall();
    bus.DecodeReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, bus.IMemAddress} !== {1'b1, mem[2], 32'd12, 32'd12}) begin
        errors++; $display("FAIL stall_hold_%0d actual=%b/%h/%h/%h required=1/%h/c/c", k, bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, bus.IMemAddress, mem[2]);
      end
    end
    bus.DecodeReady = 1'b1;
    tick();
    checks++;
    if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out} !== {1'b1, mem[3], 32'd16}) begin
      errors++; $display("FAIL stall_release actual=%b/%h/%h required=1/%h/10", bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, mem[3]);
    end
  endtask

  task automatic test_redirect();
    bus.Redirect = 1'b1; bus.RedirectTarget = 32'h0000_000B; bus.DecodeReady = 1'b0;
    tick();
    checks++;
    if ({bus.IMemAddress, bus.ValidOut} !== {32'd8, 1'b0}) begin
      errors++; $display("FAIL redirect_flush actual=%h/%b required=8/0", bus.IMemAddress, bus.ValidOut);
    end
    bus.Redirect = 1'b0;
    tick();
    checks++;
    if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out} !== {1'b1, mem[2], 32'd12}) begin
      errors++; $display("FAIL redirect_target actual=%b/%h/%h required=1/%h/c", bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, mem[2]);
    end
  endtask

  task automatic test_bounds();
    bit saw_last;
    bit halted_seen;
    saw_last = 1'b0; halted_seen = 1'b0;
    bus.DecodeReady = 1'b1;
    for (int k = 0; k < 20 && !halted_seen; k++) begin
      tick();
      if (bus.ValidOut && bus.PCPlus4Out == 32'h20 && bus.InstrOut == mem[7]) saw_last = 1'b1;
      if (bus.Halted) halted_seen = 1'b1;
    end
    checks++;
    if (!(saw_last && halted_seen)) begin
      errors++; $display("FAIL bounds_reach_halt actual=last%0b/halt%0b required=1/1 within 20 cycles", saw_last, halted_seen);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bus.Halted, bus.IMemAddress, bus.ValidOut} !== {1'b1, 32'h20, 1'b0}) begin
        errors++; $display("FAIL bounds_hold_%0d actual=%b/%h/%b required=1/20/0", k, bus.Halted, bus.IMemAddress, bus.ValidOut);
      end
      bus.DecodeReady = 1'($urandom_range(0, 1));
      tick();
    end
    bus.Redirect = 1'b1; bus.RedirectTarget = 32'h0; bus.DecodeReady = 1'b1;
    tick();
    checks++;
    if ({bus.Halted, bus.ValidOut, bus.IMemAddress} !== {1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL bounds_redirect actual=%b/%b/%h required=0/0/0", bus.Halted, bus.ValidOut, bus.IMemAddress);
    end
    bus.Redirect = 1'b0;
    tick();
    checks++;
    if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out} !== {1'b1, mem[0], 32'd4}) begin
      errors++; $display("FAIL bounds_restart actual=%b/%h/%h required=1/%h/4", bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    bus.DecodeReady = 1'b0;
    tick();
    Rst = 1'b1; bus.Redirect = 1'b1; bus.RedirectTarget = 32'h0000_0010;
    tick();
    checks++;
    if (act_vec() !== {RESET_PC, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid actual=%h required=%h", act_vec(), {RESET_PC, 96'd0, 2'b00});
    end
    Rst = 1'b0; bus.Redirect = 1'b0; bus.DecodeReady = 1'b1;
    tick();
    checks++;
    if (bus.ValidOut !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle actual=%b required=0", bus.ValidOut);
    end
    tick();
    checks++;
    if ({bus.ValidOut, bus.InstrOut, bus.PCPlus4Out} !== {1'b1, mem[0], 32'd4}) begin
      errors++; $display("FAIL reset_mid_restart actual=%b/%h/%h required=1/%h/4", bus.ValidOut, bus.InstrOut, bus.PCPlus4Out, mem[0]);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 800; k++) begin
      Rst              = ($urandom_range(0, 99) < 2);
      bus.DecodeReady  = ($urandom_range(0, 99) < 70);
      bus.Redirect     = ($urandom_range(0, 99) < 6);
      bus.RedirectTarget = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, (MEM_WORDS + 2) * 4 - 1));
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random_cycle_%0d actual=%h required=%h", k, act_vec(), exp_vec());
      end
`ifdef FETCH_PERF_COUNT_EN
      checks++;
      if ({bus.FetchCount, bus.StallCount} !== {m_fc, m_sc}) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random_counters_%0d actual=%0d/%0d required=%0d/%0d", k, bus.FetchCount, bus.StallCount, m_fc, m_sc);
      end
`endif
    end
    Rst = 1'b0; bus.Redirect = 1'b0;
  endtask

  task automatic test_perf();
    Rst = 1'b1; bus.Redirect = 1'b0; bus.DecodeReady = 1'b1;
    tick();
    Rst = 1'b0; bus.Redirect = 1'b1; bus.RedirectTarget = 32'd12;
    tick();
    bus.Redirect = 1'b0;
    tick(); tick();
    bus.DecodeReady = 1'b0;
    tick(); tick();
    bus.DecodeReady = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({bus.Halted, bus.ValidOut} !== 2'b10) begin
      errors++; $display("FAIL perf_halt actual=%b/%b required=1/0", bus.Halted, bus.ValidOut);
    end
`ifdef FETCH_PERF_COUNT_EN
    for (int k = 0; k < 6; k++) begin
      bus.DecodeReady = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({bus.FetchCount, bus.StallCount} !== {32'd5, 32'd2}) begin
        errors++; $display("FAIL perf_counts_%0d actual=%0d/%0d required=5/2", k, bus.FetchCount, bus.StallCount);
      end
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    Rst = 1'b1; bus.DecodeReady = 1'b0; bus.Redirect = 1'b0; bus.RedirectTarget = '0;
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_bounds();
    test_reset_mid();
    test_random();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
